// File: rtl/frame_stream_gen.sv
// Raster stream source: walks a stored frame in raster order and emits vsync/hsync/de/data.
// Build option FRAME_STREAM_TESTPAT_EN replaces the memory read with an (h + v) test pattern.
module frame_stream_gen #(
  parameter int WIDTH  = 8,
  parameter int H_RES  = 170,
  parameter int V_RES  = 240,
  parameter int H_FP   = 2,
  parameter int H_SYNC = 4,
  parameter int H_BP   = 2,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 1,
  parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic              i_continuous,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]  i_rd_data,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_de,
  output logic [WIDTH-1:0]  o_data
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL + 1);
  localparam int VC_W    = $clog2(V_TOTAL + 1);

  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT  = HC_W'(H_RES);
  localparam logic [HC_W-1:0] HS_BEG = HC_W'(H_RES + H_FP);
  localparam logic [HC_W-1:0] HS_END = HC_W'(H_RES + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT  = VC_W'(V_RES);
  localparam logic [VC_W-1:0] VS_BEG = VC_W'(V_RES + V_FP);
  localparam logic [VC_W-1:0] VS_END = VC_W'(V_RES + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state, state_next;
  logic            flush_cnt;
  logic            done_next;
  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;
  logic            line_end, frame_end;
  logic            active, hs, vs;
  logic            de1, hs1, vs1;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign active    = (state == RUN) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs        = (state == RUN) && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs        = (state == RUN) && (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:    if (i_start && !o_busy) state_next = RUN;
      RUN:     if (frame_end) state_next = FLUSH;
      FLUSH: begin
        if (flush_cnt) begin
          done_next  = 1'b1;
          state_next = i_continuous ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // o_busy stays high through the o_frame_done cycle; a start seen then is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      flush_cnt    <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_next;
      flush_cnt    <= (state == FLUSH) ? ~flush_cnt : 1'b0;
      o_frame_done <= done_next;
      o_busy       <= (state_next != IDLE) || done_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state == RUN) begin
      h_cnt <= line_end ? '0 : h_cnt + 1'b1;
      if (line_end) v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      de1     <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      o_de    <= 1'b0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
    end else begin
      de1     <= active;
      hs1     <= hs;
      vs1     <= vs;
      o_de    <= de1;
      o_hsync <= hs1;
      o_vsync <= vs1;
    end
  end

`ifdef FRAME_STREAM_TESTPAT_EN
  logic [WIDTH-1:0] pat1, data_reg;
  logic             rd_data_unused;

  assign rd_data_unused = ^i_rd_data;
  assign o_rd_en        = 1'b0;
  assign o_rd_addr      = '0;
  assign o_data         = data_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat1     <= '0;
      data_reg <= '0;
    end else begin
      pat1     <= WIDTH'(h_cnt) + WIDTH'(v_cnt);
      data_reg <= de1 ? pat1 : '0;
    end
  end
`else
  logic [ADDR_W-1:0] addr_cnt;

  // Memory returns data in the cycle after the strobe, which is exactly when o_de is up.
  assign o_data = o_de ? i_rd_data : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_cnt  <= '0;
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
    end else begin
      o_rd_en <= active;
      if (active) o_rd_addr <= addr_cnt;
      if (state != RUN)  addr_cnt <= '0;
      else if (active)   addr_cnt <= addr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_stream_gen.sv
// Directed bench for frame_stream_gen on a 4x3 frame (H_TOTAL=7, V_TOTAL=6).
// Checkpoint table for one frame, then continuous, mid-frame reset and start-while-busy sequences.
module tb_frame_stream_gen;

`ifdef FRAME_STREAM_TESTPAT_EN
  localparam int TP = 1;
`else
  localparam int TP = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_start = 1'b0;
  logic       i_continuous = 1'b0;
  logic       o_busy, o_frame_done, o_rd_en;
  logic [3:0] o_rd_addr;
  logic [7:0] i_rd_data = 8'd0;
  logic       o_vsync, o_hsync, o_de;
  logic [7:0] o_data;
  logic [7:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  frame_stream_gen #(
    .WIDTH(8), .H_RES(4), .V_RES(3), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_continuous(i_continuous),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_rd_en(o_rd_en),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_vsync(o_vsync),
    .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " done"}, o_frame_done, 0);
    chk({tag, " rd_en"}, o_rd_en, 0);
    chk({tag, " rd_addr"}, o_rd_addr, 0);
    chk({tag, " vsync"}, o_vsync, 0);
    chk({tag, " hsync"}, o_hsync, 0);
    chk({tag, " de"}, o_de, 0);
    chk({tag, " data"}, o_data, 0);
  endtask

  typedef struct {
    int cyc; int start; int rd_en; int addr; int de; int hs; int vs;
    int data; int tp; int busy; int done;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    int p, de_idx, de_cnt, rd_cnt, hs_cnt, vs_cnt, done_cnt, zero_viol;
    int dones, rd_run, busy_drop, busy_cnt;
    int dcyc [3];
    int rd_per [3];
    int first_addr [3];
    bit got_first;
    vec_t v;

    for (int a = 0; a < 16; a++) mem[a] = 8'(a);

    //          cyc st rd ad de hs vs dat tp bs dn
    vecs[0]  = '{0,  1, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    vecs[1]  = '{1,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0};
    vecs[2]  = '{2,  0, 1, 0, 0, 0, 0, 0,  0, 1, 0};
    vecs[3]  = '{3,  0, 1, 1, 1, 0, 0, 0,  0, 1, 0};
    vecs[4]  = '{4,  0, 1, 2, 1, 0, 0, 1,  1, 1, 0};
    vecs[5]  = '{6,  0, 0, 0, 1, 0, 0, 3,  3, 1, 0};
    vecs[6]  = '{7,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0};
    vecs[7]  = '{8,  0, 0, 0, 0, 1, 0, 0,  0, 1, 0};
    vecs[8]  = '{9,  0, 1, 4, 0, 0, 0, 0,  0, 1, 0};
    vecs[9]  = '{10, 1, 1, 5, 1, 0, 0, 4,  1, 1, 0};
    vecs[10] = '{13, 0, 0, 0, 1, 0, 0, 7,  4, 1, 0};
    vecs[11] = '{19, 0, 1, 11, 1, 0, 0, 10, 4, 1, 0};
    vecs[12] = '{20, 0, 0, 0, 1, 0, 0, 11, 5, 1, 0};
    vecs[13] = '{21, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0};
    vecs[14] = '{31, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0};
    vecs[15] = '{36, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0};
    vecs[16] = '{37, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0};
    vecs[17] = '{38, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0};
    vecs[18] = '{43, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0};
    vecs[19] = '{45, 1, 0, 0, 0, 0, 0, 0,  0, 1, 1};
    vecs[20] = '{46, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame with starts at cycle 10 (mid-frame) and 45 (done cycle) that must be ignored
    p = 0; de_idx = 0; rd_cnt = 0; hs_cnt = 0; vs_cnt = 0; done_cnt = 0; zero_viol = 0;
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) @(negedge clk);
      if (p < NV && vecs[p].cyc == c) begin
        v = vecs[p];
        chk($sformatf("rd_en@%0d", c), o_rd_en, (TP != 0) ? 0 : v.rd_en);
`ifndef FRAME_STREAM_TESTPAT_EN
        if (v.rd_en != 0) chk($sformatf("rd_addr@%0d", c), o_rd_addr, v.addr);
`endif
        chk($sformatf("de@%0d", c), o_de, v.de);
        chk($sformatf("hsync@%0d", c), o_hsync, v.hs);
        chk($sformatf("vsync@%0d", c), o_vsync, v.vs);
        chk($sformatf("data@%0d", c), o_data, (TP != 0) ? v.tp : v.data);
        chk($sformatf("busy@%0d", c), o_busy, v.busy);
        chk($sformatf("done@%0d", c), o_frame_done, v.done);
        i_start = (v.start != 0);
        p++;
      end else begin
        i_start = 1'b0;
      end
      if (o_de) begin
        chk($sformatf("pixel%0d", de_idx), o_data,
            (TP != 0) ? (de_idx % 4 + de_idx / 4) : de_idx);
        de_idx++;
      end else if (o_data != 8'd0) begin
        zero_viol++;
      end
      if (o_rd_en) rd_cnt++;
      if (o_hsync) hs_cnt++;
      if (o_vsync) vs_cnt++;
      if (o_frame_done) begin
        done_cnt++;
        $display("single frame: frame_done at cycle %0d", c);
      end
    end
    chk("de_count", de_idx, 12);
    chk("rd_count", rd_cnt, (TP != 0) ? 0 : 12);
    chk("hsync_count", hs_cnt, 6);
    chk("vsync_count", vs_cnt, 7);
    chk("done_count", done_cnt, 1);
    chk("data_zero_when_no_de", zero_viol, 0);
    chk("table_visited", p, NV);

    // Continuous mode: three frames, continuous dropped after the second done
    dones = 0; rd_run = 0; busy_drop = 0; got_first = 1'b0;
    for (int k = 0; k < 3; k++) begin dcyc[k] = -1; rd_per[k] = -1; first_addr[k] = -1; end
    @(negedge clk);
    i_start = 1'b1;
    i_continuous = 1'b1;
    for (int c = 1; c < 200 && dones < 3; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (!o_busy) busy_drop++;
      if (o_rd_en) begin
        if (!got_first) begin first_addr[dones] = int'(o_rd_addr); got_first = 1'b1; end
        rd_run++;
      end
      if (o_frame_done) begin
        dcyc[dones] = c;
        rd_per[dones] = rd_run;
        rd_run = 0;
        got_first = 1'b0;
        $display("continuous: frame %0d done at cycle %0d", dones, c);
        dones++;
        if (dones == 2) i_continuous = 1'b0;
      end
    end
    chk("cont_done_count", dones, 3);
    chk("cont_first_done_cycle", dcyc[0], 45);
    chk("cont_period_1", dcyc[1] - dcyc[0], 44);
    chk("cont_period_2", dcyc[2] - dcyc[1], 44);
    chk("cont_busy_held", busy_drop, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cont_reads_frame%0d", k), rd_per[k], (TP != 0) ? 0 : 12);
`ifndef FRAME_STREAM_TESTPAT_EN
      chk($sformatf("cont_first_addr_frame%0d", k), first_addr[k], 0);
`endif
    end
    @(negedge clk);
    chk("cont_busy_after_stop", o_busy, 0);
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_frame_done || o_de) done_cnt++;
    end
    chk("cont_no_restart", done_cnt, 0);

    // Reset mid-line while address 6 is being read
    i_start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
`ifndef FRAME_STREAM_TESTPAT_EN
    chk("pre_reset_addr", o_rd_addr, 6);
`endif
    chk("pre_reset_de", o_de, 1);
    rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_frame_done) done_cnt++;
      if (o_busy) busy_cnt++;
    end
    chk("post_reset_no_done", done_cnt, 0);
    chk("post_reset_idle", busy_cnt, 0);

    // Restart after reset begins from address 0
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    chk("restart_rd_en", o_rd_en, (TP != 0) ? 0 : 1);
`ifndef FRAME_STREAM_TESTPAT_EN
    chk("restart_addr", o_rd_addr, 0);
`endif
    @(negedge clk);
    chk("restart_de", o_de, 1);
    chk("restart_data", o_data, 0);
    @(negedge clk);
    chk("restart_data2", o_data, 1);
    done_cnt = 0;
    for (int c = 0; c < 100 && done_cnt == 0; c++) begin
      @(negedge clk);
      if (o_frame_done) done_cnt++;
    end
    chk("restart_done_seen", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
